apb4_slave_bridge: RTL and testbench

- APB4 completer that converts APB4 SETUP/ACCESS transfers into the single-request / single-ack register bus consumed by the CSR/RegMap block.
- Sits directly upstream of the RegMap. Its bus_* ports drive the BUS side of the APB-to-RegMap bus interface one-to-one.
- Adds wait-state generation, misalignment rejection and a response timeout so a hung RegMap cannot lock the APB.

---
 rtl/apb4_slave_bridge.sv | 141 ++++++++++++++
 tb/tb_apb4_slave_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_slave_bridge.sv
// APB4 completer bridging SETUP/ACCESS transfers onto the single-request /
// single-ack RegMap bus, with wait states, misalignment rejection and a
// response timeout so a hung RegMap cannot lock the APB.
module apb4_slave_bridge #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 11,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    parameter int unsigned ERR_ON_MISALIGN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    output logic                    bus_req_stall_wr,
    output logic                    bus_req_stall_rd,
    input  logic                    bus_ready,
    input  logic                    bus_err,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam bit          REJECT_MIS = (ERR_ON_MISALIGN != 0);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   w_setup;
    logic                   w_reject;
    logic                   w_timeout;
    logic [DATA_WIDTH-1:0]  w_biten;
    logic                   w_unused_pprot;

    assign w_setup        = psel & ~penable;
    assign w_reject       = REJECT_MIS && ((paddr & ALIGN_MASK) != '0);
    assign w_timeout      = TIMEOUT_EN && (r_cnt == CNT_LAST);
    assign w_unused_pprot = ^pprot;

    // Expand byte strobes to a per-bit write enable; reads never enable bits.
    always_comb begin
        w_biten = '0;
        for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            w_biten[8*i +: 8] = {8{pstrb[i] & pwrite}};
        end
    end

    // Transfer FSM with all APB and bus outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            pready           <= 1'b0;
            prdata           <= '0;
            pslverr          <= 1'b0;
            bus_req          <= 1'b0;
            bus_req_is_wr    <= 1'b0;
            bus_addr         <= '0;
            bus_wr_data      <= '0;
            bus_wr_biten     <= '0;
            bus_req_stall_wr <= 1'b0;
            bus_req_stall_rd <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        bus_addr      <= paddr;
                        bus_req_is_wr <= pwrite;
                        bus_wr_data   <= pwdata;
                        bus_wr_biten  <= w_biten;
                        r_cnt         <= '0;
                        if (w_reject) begin
                            r_state <= ST_DONE;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            prdata  <= '0;
                        end else begin
                            r_state          <= ST_REQ;
                            bus_req          <= 1'b1;
                            bus_req_stall_wr <= pwrite;
                            bus_req_stall_rd <= ~pwrite;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    bus_req <= 1'b0;
                    if (bus_ready) begin
                        r_state          <= ST_DONE;
                        pready           <= 1'b1;
                        pslverr          <= bus_err;
                        prdata           <= bus_req_is_wr ? '0 : bus_rd_data;
                        bus_req_stall_wr <= 1'b0;
                        bus_req_stall_rd <= 1'b0;
                    end else if (r_state == ST_REQ) begin
                        r_state <= ST_WAIT;
                    end else if (w_timeout) begin
                        r_state          <= ST_DONE;
                        pready           <= 1'b1;
                        pslverr          <= 1'b1;
                        prdata           <= '0;
                        bus_req_stall_wr <= 1'b0;
                        bus_req_stall_rd <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_slave_bridge.sv
// Randomized self-checking bench for apb4_slave_bridge against a
// transfer-level model of APB completion timing and RegMap responses.
module tb_apb4_slave_bridge;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 11;
    localparam int          TMO = 8;

    logic          clk;
    logic          rst;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          bus_req;
    logic          bus_req_is_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_wr_biten;
    logic          bus_req_stall_wr;
    logic          bus_req_stall_rd;
    logic          bus_ready;
    logic          bus_err;
    logic [DW-1:0] bus_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_slave_bridge #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .TIMEOUT_CYCLES  (TMO),
        .ERR_ON_MISALIGN (1)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .pprot            (pprot),
        .pready           (pready),
        .prdata           (prdata),
        .pslverr          (pslverr),
        .bus_req          (bus_req),
        .bus_req_is_wr    (bus_req_is_wr),
        .bus_addr         (bus_addr),
        .bus_wr_data      (bus_wr_data),
        .bus_wr_biten     (bus_wr_biten),
        .bus_req_stall_wr (bus_req_stall_wr),
        .bus_req_stall_rd (bus_req_stall_rd),
        .bus_ready        (bus_ready),
        .bus_err          (bus_err),
        .bus_rd_data      (bus_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".pready"},  64'(pready),  64'd0);
        chk({tag, ".pslverr"}, 64'(pslverr), 64'd0);
        chk({tag, ".prdata"},  64'(prdata),  64'd0);
        chk({tag, ".bus_req"}, 64'(bus_req), 64'd0);
        chk({tag, ".stall"},   64'({bus_req_stall_wr, bus_req_stall_rd}), 64'd0);
    endtask

    // One APB transfer; d = RegMap ack delay in cycles after the bus_req cycle.
    // Called and returning on a falling edge.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] strb, input int d, input bit err,
                        input logic [DW-1:0] rdata, input bit drop_psel);
        bit            mis;
        int            done_k;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_be;
        bit            inflight;

        mis    = (addr % 4) != 0;
        exp_be = '0;
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) exp_be = exp_be | (32'hFF << (8 * b));
            end
        end
        if (mis) begin
            done_k = 1;  exp_err = 1'b1; exp_rd = '0;
        end else if (d <= TMO) begin
            done_k = d + 2; exp_err = err; exp_rd = wr ? '0 : rdata;
        end else begin
            done_k = TMO + 2; exp_err = 1'b1; exp_rd = '0;
        end

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = 3'($urandom);
        bus_ready = 1'b0;

        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            inflight = !mis && (k < done_k);
            chk("bus_req",  64'(bus_req),  64'(!mis && k == 1));
            chk("pready",   64'(pready),   64'(k == done_k));
            chk("stall_wr", 64'(bus_req_stall_wr), 64'(inflight && wr));
            chk("stall_rd", 64'(bus_req_stall_rd), 64'(inflight && !wr));
            chk("bus_addr", 64'(bus_addr), 64'(addr));
            chk("bus_is_wr", 64'(bus_req_is_wr), 64'(wr));
            chk("bus_wdata", 64'(bus_wr_data), 64'(wdata));
            chk("bus_biten", 64'(bus_wr_biten), 64'(exp_be));
            if (k == done_k) begin
                chk("pslverr", 64'(pslverr), 64'(exp_err));
                chk("prdata",  64'(prdata),  64'(exp_rd));
            end else begin
                chk("pslverr_lo", 64'(pslverr), 64'd0);
                chk("prdata_lo",  64'(prdata),  64'd0);
            end

            penable = 1'b1;
            if ((drop_psel && k >= 1) || k >= done_k) begin
                psel = 1'b0; penable = 1'b0;
            end
            bus_ready   = (!mis && k == d + 1) || (k >= done_k && $urandom_range(1) == 1);
            bus_err     = (k == d + 1) ? err : 1'($urandom);
            bus_rd_data = (k == d + 1) ? rdata : $urandom;
        end
        bus_ready = 1'b0;
    endtask

    // Idle cycles with stray RegMap acks that must be ignored.
    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_ready   = 1'($urandom);
            bus_err     = 1'($urandom);
            bus_rd_data = $urandom;
            @(negedge clk);
            chk_quiet("idle");
        end
        bus_ready = 1'b0;
    endtask

    // Reset asserted mid-WAIT must clear everything at once.
    task automatic reset_in_wait();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 11'h044;
        pwdata = 32'hA5A5_5A5A; pstrb = 4'hF; bus_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            penable = 1'b1;
        end
        chk("pre_rst.stall_wr", 64'(bus_req_stall_wr), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk_quiet("rst");
        chk("rst.bus_addr",  64'(bus_addr),      64'd0);
        chk("rst.is_wr",     64'(bus_req_is_wr), 64'd0);
        chk("rst.wdata",     64'(bus_wr_data),   64'd0);
        chk("rst.biten",     64'(bus_wr_biten),  64'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");
    endtask

    initial begin
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
        #12;
        chk_quiet("reset");
        chk("reset.bus_addr", 64'(bus_addr), 64'd0);
        chk("reset.biten",    64'(bus_wr_biten), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        xfer(1'b1, 11'h010, 32'hDEADBEEF, 4'b0101, 0, 1'b0, $urandom, 1'b0);
        xfer(1'b0, 11'h020, $urandom, 4'hF, 3, 1'b0, 32'h12345678, 1'b0);
        xfer(1'b1, 11'h030, $urandom, 4'hF, 1, 1'b1, $urandom, 1'b0);
        xfer(1'b0, 11'h034, $urandom, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
        xfer(1'b0, 11'h006, $urandom, 4'h0, 0, 1'b0, $urandom, 1'b0);
        xfer(1'b0, 11'h040, $urandom, 4'h0, TMO + 1, 1'b0, 32'h1111_2222, 1'b0);
        idle(4);
        xfer(1'b0, 11'h048, $urandom, 4'h0, TMO, 1'b0, 32'h8765_4321, 1'b0);
        reset_in_wait();
        xfer(1'b0, 11'h050, $urandom, 4'h0, 2, 1'b0, 32'h0BAD_BEEF, 1'b0);
        xfer(1'b1, 11'h054, $urandom, 4'b1010, 2, 1'b0, $urandom, 1'b1);

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            if ($urandom_range(3) != 0) a = a & ~AW'(3);
            xfer(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(TMO + 2)),
                 1'($urandom), $urandom, ($urandom_range(7) == 0));
            if ($urandom_range(1) == 1) idle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
